// File: rtl/mux3_sel_arbiter_if.sv
// Request/grant bundle between three requesters and the round-robin arbiter
// that steers the shared 3:1 mux.
//
// Handshake: a requester holds req[n] high for as long as it wants the mux.
// The arbiter answers with a registered one-hot gnt one cycle later. The owner
// keeps gnt while req[n] stays high, for at most HOLD_CYCLES consecutive cycles.
// When req[n] drops, or when the hold limit is reached, ownership passes to the
// next requester in round-robin order. A grant is never withdrawn for any
// other reason, except by reset.
interface mux3_sel_arbiter_if #(
    parameter int CNT_W = 3
);
    logic [2:0]       req;
    logic [2:0]       gnt;
    logic             s1;
    logic             s0;
    logic             valid;
    logic [CNT_W-1:0] beat_cnt;
    logic             state_dbg;   // 1 while the arbiter FSM is in GRANT

    // Arbiter side.
    modport master (
        input  req,
        output gnt, s1, s0, valid, beat_cnt, state_dbg
    );

    // Requester side.
    modport slave (
        output req,
        input  gnt, s1, s0, valid, beat_cnt, state_dbg
    );
endinterface

// File: rtl/mux3_sel_arbiter.sv
// Round-robin arbiter that drives the s1/s0 select lines of a 3:1 mux.
// The grant, the select lines and the hold counter are all registered.
// Priority starts just after the last owner and wraps around, so the current
// owner has the lowest priority. The hold limit stops any one requester from
// starving the other two.
module mux3_sel_arbiter #(
    parameter int HOLD_CYCLES = 4,   // >= 1
    parameter int CNT_W       = 3    // must be wide enough to hold HOLD_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    mux3_sel_arbiter_if.master  bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [2:0]       r_gnt;
    logic [1:0]       r_sel;      // winner index: 0 -> 00, 1 -> 01, 2 -> 10
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_last;     // last owner; it is also the current owner while in GRANT

    state_t           w_state_nxt;
    logic [2:0]       w_gnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_last_nxt;
    logic             w_arb;
    logic [1:0]       w_winner;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Round-robin search. Try last+1 first, then last+2. The last owner is
    // chosen only when it is the sole requester.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = next_idx(last);
        c2 = next_idx(c1);
        if (r[c1])      return c1;
        else if (r[c2]) return c2;
        else            return last;
    endfunction

    assign w_winner = pick(bus.req, r_last);

    // Next-state logic: extend the current grant, or re-arbitrate on release or on expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_arb       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_arb = 1'b1;
            end
            S_GRANT: begin
                if (bus.req[r_last] && (r_cnt < HOLD_MAX)) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end else begin
                    w_arb = 1'b1;
                end
            end
            default: begin
                w_arb = 1'b1;
            end
        endcase

        if (w_arb) begin
            if (|bus.req) begin
                // Switch straight to the winner, with no idle bubble between owners.
                w_state_nxt = S_GRANT;
                w_gnt_nxt   = 3'b001 << w_winner;
                w_sel_nxt   = w_winner;
                w_cnt_nxt   = CNT_ONE;
                w_last_nxt  = w_winner;
            end else begin
                // Nobody is requesting. The select lines keep their last value so the mux output does not glitch.
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 3'b000;
                w_cnt_nxt   = '0;
            end
        end
    end

    // State register. Reset makes priority start again at requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= 3'b000;
            r_sel   <= 2'b00;
            r_cnt   <= '0;
            r_last  <= 2'd2;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.s1        = r_sel[1];
    assign bus.s0        = r_sel[0];
    assign bus.valid     = |r_gnt;
    assign bus.beat_cnt  = r_cnt;
    assign bus.state_dbg = (r_state == S_GRANT);

endmodule

// File: tb/tb_mux3_sel_arbiter.sv
// Bench for mux3_sel_arbiter with HOLD_CYCLES = 4.
// A round-robin reference model tracks the owner, the hold count and the
// select lines. It pushes the expected output word for every clock edge onto
// exp_q, and each scenario task pops that word and compares it with the DUT.
module tb_mux3_sel_arbiter;

    localparam int HOLD  = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mux_i0, mux_i1, mux_i2;
    logic mux_y;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    mux3_sel_arbiter_if #(.CNT_W(CNT_W)) bus ();

    mux3_sel_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural 3:1 mux fed by the arbiter's select lines.
    assign mux_y = bus.s1 ? mux_i2 : (bus.s0 ? mux_i1 : mux_i0);

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_last  = 2;
    int m_sel   = 0;

    logic [8:0] exp_q[$];   // {gnt, s1, s0, valid, beat_cnt}

    function automatic void model_edge(input logic [2:0] r, input logic rs);
        int w;
        if (rs) begin
            m_busy = 1'b0; m_cnt = 0; m_last = 2; m_sel = 0; m_owner = 0;
        end else if (m_busy && r[m_owner] && m_cnt < HOLD) begin
            m_cnt = m_cnt + 1;
        end else begin
            w = -1;
            for (int k = 1; k <= 3; k++) begin
                if (w < 0 && r[(m_last + k) % 3]) w = (m_last + k) % 3;
            end
            if (w >= 0) begin
                m_busy = 1'b1; m_owner = w; m_last = w; m_cnt = 1; m_sel = w;
            end else begin
                m_busy = 1'b0; m_cnt = 0;
            end
        end
    endfunction

    function automatic logic [8:0] model_word();
        logic [2:0] g;
        logic [1:0] s;
        g = m_busy ? (3'b001 << m_owner) : 3'b000;
        s = 2'(m_sel);
        return {g, s, m_busy, 3'(m_cnt)};
    endfunction

    // ---------------- driver ----------------
    // Inputs change on the falling edge. Outputs are sampled on the next falling edge.
    task automatic step(input logic [2:0] r, input logic rs);
        bus.req = r;
        rst     = rs;
        @(posedge clk);
        model_edge(r, rs);
        exp_q.push_back(model_word());
        @(negedge clk);
    endtask

    function automatic logic [8:0] obs_word();
        return {bus.gnt, bus.s1, bus.s0, bus.valid, bus.beat_cnt};
    endfunction

    // ---------------- invariant monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (bus.valid !== (|bus.gnt) || {bus.s1, bus.s0} === 2'b11 ||
                (bus.valid && (bus.gnt !== (3'b001 << {bus.s1, bus.s0}))) ||
                bus.state_dbg !== bus.valid) begin
                n_err++;
                $display("FAIL invariant: gnt=%b s=%b%b valid=%b dbg=%b", bus.gnt, bus.s1, bus.s0,
                         bus.valid, bus.state_dbg);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [8:0] e;
        for (int i = 0; i < 2; i++) begin
            step(3'b111, 1'b1);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_word() !== e || obs_word() !== 9'b0) begin
                n_err++;
                $display("FAIL reset[%0d]: got %b want %b", i, obs_word(), e);
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        logic [8:0] e;
        step(3'b000, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 12; i++) begin
            step(3'b010, 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_word() !== e || bus.gnt !== 3'b010 || bus.beat_cnt !== 3'((i % 4) + 1)) begin
                n_err++;
                $display("FAIL single[%0d]: got %b want %b", i, obs_word(), e);
            end
        end
    endtask

    task automatic test_rotate();
        logic [8:0] e;
        logic [2:0] g;
        step(3'b000, 1'b1);
        void'(exp_q.pop_front());
        mux_i0 = 1'b1; mux_i1 = 1'b0; mux_i2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(3'b111, 1'b0);
            e = exp_q.pop_front();
            g = 3'b001 << ((i / 4) % 3);
            n_cmp++;
            if (obs_word() !== e || bus.gnt !== g || mux_y !== ((i / 4) % 3 != 1)) begin
                n_err++;
                $display("FAIL rotate[%0d]: got %b y=%b want %b gnt %b", i, obs_word(), mux_y, e, g);
            end
        end
    endtask

    task automatic test_release();
        logic [8:0] e;
        logic [2:0] seq [3];
        seq[0] = 3'b001; seq[1] = 3'b101; seq[2] = 3'b100;
        step(3'b000, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            step(seq[i], 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_word() !== e) begin
                n_err++;
                $display("FAIL release[%0d]: got %b want %b", i, obs_word(), e);
            end
        end
        n_cmp++;
        if (obs_word() !== 9'b100_10_1_001) begin
            n_err++;
            $display("FAIL release_switch: got %b want %b", obs_word(), 9'b100_10_1_001);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        logic [2:0] r [5];
        logic       rs [5];
        r[0] = 3'b000; rs[0] = 1'b1;
        r[1] = 3'b010; rs[1] = 1'b0;
        r[2] = 3'b111; rs[2] = 1'b0;
        r[3] = 3'b111; rs[3] = 1'b1;
        r[4] = 3'b111; rs[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(r[i], rs[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_word() !== e) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got %b want %b", i, obs_word(), e);
            end
        end
        n_cmp++;
        if (bus.gnt !== 3'b001) begin
            n_err++;
            $display("FAIL reset_mid_first: got gnt %b want 001", bus.gnt);
        end
    endtask

    task automatic test_wrap();
        logic [8:0] e;
        logic       exp_y;
        step(3'b000, 1'b1);
        void'(exp_q.pop_front());
        mux_i0 = 1'b1; mux_i1 = 1'b0; mux_i2 = 1'b1;
        step(3'b100, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 6; i++) begin
            step((i < 4) ? 3'b111 : 3'b110, 1'b0);
            e = exp_q.pop_front();
            exp_y = (m_sel == 0) ? mux_i0 : ((m_sel == 1) ? mux_i1 : mux_i2);
            n_cmp++;
            if (obs_word() !== e || mux_y !== exp_y) begin
                n_err++;
                $display("FAIL wrap[%0d]: got %b y=%b want %b y=%b", i, obs_word(), mux_y, e, exp_y);
            end
            if (i == 3) begin
                n_cmp++;
                if (bus.gnt !== 3'b001 || {bus.s1, bus.s0} !== 2'b00) begin
                    n_err++;
                    $display("FAIL wrap_to_0: got gnt %b s %b%b want 001 00", bus.gnt, bus.s1, bus.s0);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] e;
        logic [2:0] r;
        int         hold_len;
        int         i;
        i = 0;
        while (i < 400) begin
            r = 3'($urandom_range(0, 7));
            hold_len = $urandom_range(1, 6);
            for (int k = 0; k < hold_len; k++) begin
                mux_i0 = 1'($urandom); mux_i1 = 1'($urandom); mux_i2 = 1'($urandom);
                step(r, ($urandom_range(0, 59) == 0));
                e = exp_q.pop_front();
                n_cmp++;
                if (obs_word() !== e) begin
                    n_err++;
                    $display("FAIL random[%0d]: req=%b got %b want %b", i, r, obs_word(), e);
                end
                i++;
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- sequence + report ----------------
    initial begin
        bus.req = 3'b000;
        mux_i0 = 1'b0; mux_i1 = 1'b0; mux_i2 = 1'b0;
        test_reset();
        test_single();
        test_rotate();
        test_release();
        test_reset_mid();
        test_wrap();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL exp_q_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
